// File: rtl/tilexy_snoop_resp_pkg.sv
// tilexy_pkg: shared definitions for the tile-mesh snoop responder.
//   - Bit positions of the address-request (AREQ_*) and write-request /
//     data-return (WRREQ_*) packet fields, plus the two packet widths.
//   - Responder state enum and the compact FIFO entry kept per request.
//   - Helpers to pull an entry out of a request packet and to build a
//     full data-return packet.
package tilexy_pkg;

  localparam int AREQ_W  = 165;
  localparam int WRREQ_W = 732;

  localparam int ADDR_W = 37;
  localparam int LINE_W = 528;
  localparam int PHY_W  = 40;

  // Address-request fields
  localparam int AREQ_ADDR_LO = 0;
  localparam int AREQ_ADDR_HI = 36;
  localparam int AREQ_EXCL    = 39;
  localparam int AREQ_SRCY_LO = 70;
  localparam int AREQ_SRCY_HI = 71;
  localparam int AREQ_SRCX_LO = 72;
  localparam int AREQ_SRCX_HI = 73;
  localparam int AREQ_TX_LO   = 76;
  localparam int AREQ_TX_HI   = 80;
  localparam int AREQ_TY_LO   = 81;
  localparam int AREQ_TY_HI   = 85;
  localparam int AREQ_SZ_LO   = 86;
  localparam int AREQ_SZ_HI   = 125;
  localparam int AREQ_SND     = 163;

  // Write-request (data-return) fields
  localparam int WRREQ_DATA_LO = 0;
  localparam int WRREQ_DATA_HI = 527;
  localparam int WRREQ_XDONE   = 528;
  localparam int WRREQ_YDONE   = 529;
  localparam int WRREQ_TX_LO   = 530;
  localparam int WRREQ_TX_HI   = 534;
  localparam int WRREQ_TY_LO   = 535;
  localparam int WRREQ_TY_HI   = 539;
  localparam int WRREQ_SZ_LO   = 540;
  localparam int WRREQ_SZ_HI   = 579;
  localparam int WRREQ_SHARED  = 580;
  localparam int WRREQ_ADDR_LO = 581;
  localparam int WRREQ_ADDR_HI = 728;
  localparam int WRREQ_SND     = 729;
  localparam int WRREQ_EXPUN   = 730;
  localparam int WRREQ_EXTRA   = 731;

  // Cycles spent in WAIT before a lookup is abandoned (timeout build only)
  localparam int TIMEOUT_CYC = 31;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_WAIT   = 2'd2,
    ST_SEND   = 2'd3
  } snoop_state_t;

  // Only the fields the response needs are queued, not the whole packet.
  typedef struct packed {
    logic [1:0]        src_x;
    logic [1:0]        src_y;
    logic              want_excl;
    logic [ADDR_W-1:0] addr;
  } areq_entry_t;

  function automatic areq_entry_t unpack_areq(input logic [AREQ_W-1:0] p);
    areq_entry_t e;
    e.src_x     = p[AREQ_SRCX_HI:AREQ_SRCX_LO];
    e.src_y     = p[AREQ_SRCY_HI:AREQ_SRCY_LO];
    e.want_excl = p[AREQ_EXCL];
    e.addr      = p[AREQ_ADDR_HI:AREQ_ADDR_LO];
    return e;
  endfunction

  // A miss (hit=0) returns an all-zero line with expun set as the nack.
  function automatic logic [WRREQ_W-1:0] build_wrreq(
    input areq_entry_t       e,
    input logic              hit,
    input logic [LINE_W-1:0] data,
    input logic [PHY_W-1:0]  phy,
    input logic              xdone,
    input logic              ydone,
    input logic              extra
  );
    logic [WRREQ_W-1:0] p;
    p = '0;
    p[WRREQ_DATA_HI:WRREQ_DATA_LO] = hit ? data : '0;
    p[WRREQ_XDONE]                 = xdone;
    p[WRREQ_YDONE]                 = ydone;
    p[WRREQ_TX_HI:WRREQ_TX_LO]     = {3'b000, e.src_x};
    p[WRREQ_TY_HI:WRREQ_TY_LO]     = {3'b000, e.src_y};
    p[WRREQ_SZ_HI:WRREQ_SZ_LO]     = phy;
    p[WRREQ_SHARED]                = ~e.want_excl;
    p[WRREQ_ADDR_HI:WRREQ_ADDR_LO] = {4{e.addr}};
    p[WRREQ_SND]                   = 1'b1;
    p[WRREQ_EXPUN]                 = ~hit;
    p[WRREQ_EXTRA]                 = extra;
    return p;
  endfunction

endpackage

// File: rtl/tilexy_snoop_fifo.sv
// tilexy_snoop_fifo: 2-write / 1-read ingress queue of pending requests.
//   clk, rst_n      clock, async active-low reset
//   push[1:0]       write enables; link0 lands before link1 in one cycle
//   wr_data0/1      entries for link0 / link1
//   pop             drop the head entry
//   rd_data         head entry (valid while !empty)
//   count, empty    occupancy
// The caller guarantees free space for both writes (credit-gated).
module tilexy_snoop_fifo
  import tilexy_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               push,
  input  areq_entry_t              wr_data0,
  input  areq_entry_t              wr_data1,
  input  logic                     pop,
  output areq_entry_t              rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  areq_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push[0]) mem[wr_ptr] <= wr_data0;
    if (push[1]) mem[wr_ptr + AW'(push[0])] <= wr_data1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push[0]) + AW'(push[1]);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push[0]) + CW'(push[1]) - CW'(pop);
    end
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);

endmodule

// File: rtl/tilexy_snoop_resp.sv
// tilexy_snoop_resp: responder end of the tile-mesh miss-address protocol.
// Queues address requests addressed to this tile, looks each up in the local
// cache slice one at a time, and returns a full-line data packet (or nack)
// toward the requester.
//   clk, rst_n        clock, async active-low reset
//   areq_in/areq_rdy  two request links and their shared accept credit
//   lk_*              lookup strobe/request and cache result
//   rsp_out/vld/rdy   two response links (only one active at a time)
//   err_ovf           sticky: a matching request arrived without credit
// Optional build macro TILEXY_SNOOP_TIMEOUT_EN: abandon a lookup after
// TIMEOUT_CYC cycles in WAIT and send a nack with sz=0.
//
// state  | meaning
// IDLE   | waiting for a queued request; latches head into working reg
// LOOKUP | lk_en high for this single cycle
// WAIT   | waiting for lk_rsp_vld; head is popped when it arrives
// SEND   | rsp_vld held on the routed link until rsp_rdy
module tilexy_snoop_resp
  import tilexy_pkg::*;
#(
  parameter int TILE_X = 0,
  parameter int TILE_Y = 0,
  parameter int IDX    = 0,
  parameter int DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0][AREQ_W-1:0]    areq_in,
  output logic [1:0]                areq_rdy,
  output logic                      lk_en,
  output logic [ADDR_W-1:0]         lk_addr,
  output logic                      lk_want_shared,
  output logic                      lk_want_excl,
  input  logic                      lk_rsp_vld,
  input  logic                      lk_hit,
  input  logic [LINE_W-1:0]         lk_data,
  input  logic [PHY_W-1:0]          lk_phy,
  output logic [1:0][WRREQ_W-1:0]   rsp_out,
  output logic [1:0]                rsp_vld,
  input  logic [1:0]                rsp_rdy,
  output logic                      err_ovf
);

  localparam int          CW       = $clog2(DEPTH) + 1;
  localparam logic [1:0]  TILE_XL  = 2'(TILE_X);
  localparam logic [1:0]  TILE_YL  = 2'(TILE_Y);
  localparam logic        XDONE_L  = (IDX < 2);
  localparam logic        YDONE_L  = (IDX >= 2);

  snoop_state_t  state;
  areq_entry_t   wk;
  logic          wk_link;
  areq_entry_t   head;
  areq_entry_t   ent0;
  areq_entry_t   ent1;
  logic [CW-1:0] count;
  logic          empty;
  logic          credit;
  logic [1:0]    match;
  logic [1:0]    push;
  logic          pop;
  logic          extra;
  logic          head_link;

`ifdef TILEXY_SNOOP_TIMEOUT_EN
  logic [4:0]    tmo_cnt;
`endif

  always_comb begin
    match = '0;
    for (int k = 0; k < 2; k++) begin
      match[k] = areq_in[k][AREQ_SND] &&
                 (areq_in[k][AREQ_TX_HI:AREQ_TX_LO] == {3'b000, TILE_XL}) &&
                 (areq_in[k][AREQ_TY_HI:AREQ_TY_LO] == {3'b000, TILE_YL});
    end
  end

  assign credit   = (count <= CW'(DEPTH - 2));
  assign areq_rdy = {2{credit}};
  assign push     = match & {2{credit}};
  assign ent0     = unpack_areq(areq_in[0]);
  assign ent1     = unpack_areq(areq_in[1]);
  assign extra    = (count >= CW'(DEPTH / 2));

  // Link1 heads toward larger X (then larger Y); everything else, including
  // a self-addressed request, goes out on link0.
  assign head_link = (head.src_x > TILE_XL) ||
                     ((head.src_x == TILE_XL) && (head.src_y > TILE_YL));

  always_comb begin
    pop = 1'b0;
    if (state == ST_WAIT) begin
      pop = lk_rsp_vld;
`ifdef TILEXY_SNOOP_TIMEOUT_EN
      if (tmo_cnt == '0) pop = 1'b1;
`endif
    end
  end

  tilexy_snoop_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .wr_data0 (ent0),
    .wr_data1 (ent1),
    .pop      (pop),
    .rd_data  (head),
    .count    (count),
    .empty    (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf <= 1'b0;
    end else if (|(match & ~areq_rdy)) begin
      err_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      wk             <= '0;
      wk_link        <= 1'b0;
      lk_en          <= 1'b0;
      lk_addr        <= '0;
      lk_want_shared <= 1'b0;
      lk_want_excl   <= 1'b0;
      rsp_out        <= '0;
      rsp_vld        <= '0;
`ifdef TILEXY_SNOOP_TIMEOUT_EN
      tmo_cnt        <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            wk             <= head;
            wk_link        <= head_link;
            lk_en          <= 1'b1;
            lk_addr        <= head.addr;
            lk_want_excl   <= head.want_excl;
            lk_want_shared <= ~head.want_excl;
            state          <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          lk_en <= 1'b0;
          state <= ST_WAIT;
`ifdef TILEXY_SNOOP_TIMEOUT_EN
          // Down-counter reaches zero on the TIMEOUT_CYC-th cycle of WAIT.
          tmo_cnt <= 5'(TIMEOUT_CYC - 1);
`endif
        end
        ST_WAIT: begin
          if (lk_rsp_vld) begin
            rsp_out[wk_link] <= build_wrreq(wk, lk_hit, lk_data, lk_phy,
                                            XDONE_L, YDONE_L, extra);
            rsp_vld[wk_link] <= 1'b1;
            state            <= ST_SEND;
          end
`ifdef TILEXY_SNOOP_TIMEOUT_EN
          else if (tmo_cnt == '0) begin
            rsp_out[wk_link] <= build_wrreq(wk, 1'b0, '0, '0,
                                            XDONE_L, YDONE_L, extra);
            rsp_vld[wk_link] <= 1'b1;
            state            <= ST_SEND;
          end else begin
            tmo_cnt <= tmo_cnt - 5'd1;
          end
`endif
        end
        ST_SEND: begin
          if (rsp_rdy[wk_link]) begin
            rsp_out <= '0;
            rsp_vld <= '0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tilexy_snoop_resp.sv
module tb_tilexy_snoop_resp;

  localparam int TX_T  = 1;
  localparam int TY_T  = 1;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0][164:0] areq_in;
  logic [1:0]        areq_rdy;
  logic              lk_en;
  logic [36:0]       lk_addr;
  logic              lk_want_shared;
  logic              lk_want_excl;
  logic              lk_rsp_vld;
  logic              lk_hit;
  logic [527:0]      lk_data;
  logic [39:0]       lk_phy;
  logic [1:0][731:0] rsp_out;
  logic [1:0]        rsp_vld;
  logic [1:0]        rsp_rdy;
  logic              err_ovf;

  tilexy_snoop_resp #(.TILE_X(TX_T), .TILE_Y(TY_T), .IDX(0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .areq_in(areq_in), .areq_rdy(areq_rdy),
    .lk_en(lk_en), .lk_addr(lk_addr), .lk_want_shared(lk_want_shared),
    .lk_want_excl(lk_want_excl), .lk_rsp_vld(lk_rsp_vld), .lk_hit(lk_hit),
    .lk_data(lk_data), .lk_phy(lk_phy), .rsp_out(rsp_out), .rsp_vld(rsp_vld),
    .rsp_rdy(rsp_rdy), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sx;
    logic [1:0]  sy;
    logic [36:0] addr;
    logic        excl;
    logic [4:0]  tx;
    logic [4:0]  ty;
    logic        snd;
  } breq_t;

  int    checks = 0;
  int    failures = 0;
  breq_t req_q[$];
  logic  err_exp = 1'b0;
  int    lk_pulses = 0;
  logic [36:0] lk_addr_cap;
  logic  excl_cap;
  logic  shared_cap;

  task automatic chk(input string tag, input logic [527:0] obs, input logic [527:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [527:0] rnd528();
    logic [543:0] t;
    for (int i = 0; i < 17; i++) t[i*32 +: 32] = $urandom;
    return t[527:0];
  endfunction

  function automatic logic [164:0] rnd165();
    logic [191:0] t;
    for (int i = 0; i < 6; i++) t[i*32 +: 32] = $urandom;
    return t[164:0];
  endfunction

  function automatic breq_t mk(input logic [1:0] sx, input logic [1:0] sy,
                               input logic [36:0] addr, input logic excl);
    breq_t r;
    r.sx = sx; r.sy = sy; r.addr = addr; r.excl = excl;
    r.tx = 5'(TX_T); r.ty = 5'(TY_T); r.snd = 1'b1;
    return r;
  endfunction

  function automatic breq_t rnd_req();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return mk(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), t[36:0],
              1'($urandom_range(0, 1)));
  endfunction

  function automatic logic [164:0] pack(input breq_t r);
    logic [164:0] v;
    v = rnd165();
    v[36:0] = r.addr; v[39] = r.excl;
    v[73:72] = r.sx;  v[71:70] = r.sy;
    v[80:76] = r.tx;  v[85:81] = r.ty;
    v[163] = r.snd;
    return v;
  endfunction

  // Response goes toward larger X first, then larger Y; otherwise link0.
  function automatic logic route(input breq_t r);
    return (int'(r.sx) > TX_T) || (int'(r.sx) == TX_T && int'(r.sy) > TY_T);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (lk_en) begin
      lk_pulses++;
      lk_addr_cap = lk_addr;
      excl_cap    = lk_want_excl;
      shared_cap  = lk_want_shared;
    end
  endtask

  task automatic model_push(input breq_t r, input logic credit);
    if (r.snd && int'(r.tx) == TX_T && int'(r.ty) == TY_T) begin
      if (credit) req_q.push_back(r);
      else err_exp = 1'b1;
    end
  endtask

  task automatic push(input breq_t r0, input logic en0, input breq_t r1, input logic en1);
    logic credit;
    credit = (req_q.size() <= DEPTH - 2);
    areq_in = '0;
    if (en0) begin areq_in[0] = pack(r0); model_push(r0, credit); end
    if (en1) begin areq_in[1] = pack(r1); model_push(r1, credit); end
    tick();
    areq_in = '0;
  endtask

  task automatic check_rsp(input logic o, input breq_t r, input logic hit,
                           input logic [527:0] d, input logic [39:0] p, input logic extra_e);
    logic [731:0] pk;
    logic [731:0] other;
    pk = rsp_out[o];
    other = rsp_out[!o];
    chk("rsp_vld", 528'(rsp_vld), 528'(o ? 2'b10 : 2'b01));
    chk("rsp_data", pk[527:0], hit ? d : 528'(0));
    chk("rsp_xdone", 528'(pk[528]), 528'(1));
    chk("rsp_ydone", 528'(pk[529]), 528'(0));
    chk("rsp_tx", 528'(pk[534:530]), 528'(r.sx));
    chk("rsp_ty", 528'(pk[539:535]), 528'(r.sy));
    chk("rsp_sz", 528'(pk[579:540]), 528'(p));
    chk("rsp_shared", 528'(pk[580]), 528'(!r.excl));
    for (int i = 0; i < 4; i++) chk("rsp_addr", 528'(pk[581 + 37*i +: 37]), 528'(r.addr));
    chk("rsp_snd", 528'(pk[729]), 528'(1));
    chk("rsp_expun", 528'(pk[730]), 528'(!hit));
    chk("rsp_extra", 528'(pk[731]), 528'(extra_e));
    chk("rsp_other_lo", other[527:0], 528'(0));
    chk("rsp_other_hi", 528'(other[731:528]), 528'(0));
  endtask

  task automatic await_lookup(input breq_t r);
    for (int i = 0; i < 20 && lk_pulses == 0; i++) tick();
    chk("lk_pulse_count", 528'(lk_pulses), 528'(1));
    chk("lk_addr", 528'(lk_addr_cap), 528'(r.addr));
    chk("lk_want_excl", 528'(excl_cap), 528'(r.excl));
    chk("lk_want_shared", 528'(shared_cap), 528'(!r.excl));
    if (lk_en) tick();
    chk("lk_en_drop", 528'(lk_en), 528'(0));
    lk_pulses = 0;
  endtask

  task automatic release_rsp(input logic o);
    rsp_rdy = 2'b00;
    rsp_rdy[o] = 1'b1;
    tick();
    rsp_rdy = 2'b00;
    chk("rsp_vld_after_accept", 528'(rsp_vld), 528'(0));
    chk("rsp_out_after_accept", 528'(rsp_out[0] | rsp_out[1]), 528'(0));
  endtask

  task automatic serve(input logic hit, input int hold);
    breq_t r;
    logic o;
    logic extra_e;
    logic [527:0] d;
    logic [63:0] pt;
    logic [39:0] p;
    r = req_q[0];
    await_lookup(r);
    extra_e = (req_q.size() >= DEPTH / 2);
    d = rnd528();
    pt = {$urandom, $urandom};
    p = pt[39:0];
    lk_rsp_vld = 1'b1; lk_hit = hit; lk_data = d; lk_phy = p;
    tick();
    lk_rsp_vld = 1'b0; lk_hit = 1'b0; lk_data = rnd528(); lk_phy = '0;
    o = route(r);
    void'(req_q.pop_front());
    check_rsp(o, r, hit, d, p, extra_e);
    // Only the other link is ready while holding; it must not complete SEND.
    rsp_rdy = o ? 2'b01 : 2'b10;
    for (int h = 0; h < hold; h++) begin
      tick();
      check_rsp(o, r, hit, d, p, extra_e);
    end
    release_rsp(o);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    breq_t r;
    breq_t r2;
    int n;
    rst_n = 1'b0;
    areq_in = '0; lk_rsp_vld = 1'b0; lk_hit = 1'b0; lk_data = '0; lk_phy = '0;
    rsp_rdy = 2'b00;
    #12;
    chk("rst_areq_rdy", 528'(areq_rdy), 528'(2'b11));
    chk("rst_lk", 528'({lk_en, lk_want_shared, lk_want_excl, lk_addr}), 528'(0));
    chk("rst_rsp_vld", 528'(rsp_vld), 528'(0));
    chk("rst_rsp_out", 528'(rsp_out[0] | rsp_out[1]), 528'(0));
    chk("rst_err_ovf", 528'(err_ovf), 528'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Directed single request with hit, held 10 cycles before accept
    r = mk(2'd2, 2'd0, 37'h1234, 1'b0);
    push(r, 1'b1, r, 1'b0);
    tick();
    chk("lk_en_latency", 528'(lk_en), 528'(1));
    serve(1'b1, 10);
    for (int i = 0; i < 3; i++) tick();
    chk("no_duplicate_rsp", 528'(rsp_vld), 528'(0));

    // Same request, miss
    push(r, 1'b1, r, 1'b0);
    serve(1'b0, 0);

    // Non-matching packets and a stray lookup result while idle
    r2 = r; r2.snd = 1'b0;
    push(r2, 1'b1, r2, 1'b0);
    r2 = r; r2.tx = 5'd2;
    r2.ty = 5'd1;
    push(r2, 1'b0, r2, 1'b1);
    lk_rsp_vld = 1'b1; lk_hit = 1'b1;
    tick();
    lk_rsp_vld = 1'b0; lk_hit = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("ignore_lookups", 528'(lk_pulses), 528'(0));
    chk("ignore_rsp_vld", 528'(rsp_vld), 528'(0));
    chk("ignore_rdy", 528'(areq_rdy), 528'(2'b11));

    // Self-addressed request goes to link0
    r = mk(2'd1, 2'd1, 37'h1_0000_0abc, 1'b1);
    push(r, 1'b0, r, 1'b1);
    serve(1'b1, 1);

    // Randomized single requests on random links
    for (int i = 0; i < 8; i++) begin
      r = rnd_req();
      if ($urandom_range(0, 1) == 0) push(r, 1'b1, r, 1'b0);
      else push(r, 1'b0, r, 1'b1);
      serve(1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    // Simultaneous pushes: link0 served before link1
    r = rnd_req();
    r2 = rnd_req();
    push(r, 1'b1, r2, 1'b1);
    serve(1'b1, 0);
    serve(1'b0, 2);

    // Fill to DEPTH-1 with the lookup stalled, then overflow
    for (int i = 0; i < DEPTH - 1; i++) begin
      r = rnd_req();
      if (i % 2 == 0) push(r, 1'b1, r, 1'b0);
      else push(r, 1'b0, r, 1'b1);
      chk("fill_areq_rdy", 528'(areq_rdy),
          528'((req_q.size() <= DEPTH - 2) ? 2'b11 : 2'b00));
    end
    chk("fill_err_clear", 528'(err_ovf), 528'(err_exp));
    r = rnd_req();
    push(r, 1'b0, r, 1'b1);
    chk("ovf_err_set", 528'(err_ovf), 528'(err_exp));
    chk("ovf_rdy_low", 528'(areq_rdy), 528'(2'b00));
    chk("ovf_queue", 528'(req_q.size()), 528'(DEPTH - 1));
    while (req_q.size() > 0) serve(1'($urandom_range(0, 1)), $urandom_range(0, 1));
    chk("drain_rdy", 528'(areq_rdy), 528'(2'b11));
    chk("drain_err_sticky", 528'(err_ovf), 528'(1));

`ifdef TILEXY_SNOOP_TIMEOUT_EN
    // No lookup result: nack after TIMEOUT cycles, late result ignored
    r = rnd_req();
    push(r, 1'b1, r, 1'b0);
    for (int i = 0; i < 20 && lk_pulses == 0; i++) tick();
    if (lk_en) tick();
    lk_pulses = 0;
    n = 0;
    while (rsp_vld == 2'b00 && n < 40) begin tick(); n++; end
    chk("timeout_cycles", 528'(n), 528'(31));
    check_rsp(route(r), r, 1'b0, 528'(0), 40'(0), 1'b0);
    void'(req_q.pop_front());
    lk_rsp_vld = 1'b1; lk_hit = 1'b1;
    tick();
    lk_rsp_vld = 1'b0; lk_hit = 1'b0;
    release_rsp(route(r));
    for (int i = 0; i < 3; i++) tick();
    chk("late_rsp_ignored", 528'(rsp_vld), 528'(0));
`endif

    // Reset in WAIT aborts asynchronously
    r = rnd_req();
    push(r, 1'b1, r, 1'b0);
    for (int i = 0; i < 20 && lk_pulses == 0; i++) tick();
    if (lk_en) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_areq_rdy", 528'(areq_rdy), 528'(2'b11));
    chk("arst_lk", 528'({lk_en, lk_want_shared, lk_want_excl, lk_addr}), 528'(0));
    chk("arst_rsp", 528'({rsp_vld, rsp_out[0] | rsp_out[1]}), 528'(0));
    chk("arst_err_ovf", 528'(err_ovf), 528'(0));
    req_q.delete();
    err_exp = 1'b0;
    lk_pulses = 0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("arst_no_lookup", 528'(lk_pulses), 528'(0));
    chk("arst_no_rsp", 528'(rsp_vld), 528'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
